// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU control and PC-select encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_ctrl_e;

  localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_JUMP   = 2'd2;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    logic      branch;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file with same-cycle write-through and synchronous clear.
module reg_file #(
  parameter int unsigned Width = 32,
  parameter int unsigned NReg  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [4:0]       wa_i,
  input  logic [Width-1:0] wd_i,
  input  logic [4:0]       ra1_i,
  input  logic [4:0]       ra2_i,
  output logic [Width-1:0] rd1_o,
  output logic [Width-1:0] rd2_o
);

  logic [Width-1:0] mem_q [NReg];
  logic             wr_en;

  assign wr_en = we_i && (wa_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NReg); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Writeback data bypasses the array so ID sees the value being written this cycle.
  always_comb begin
    rd1_o = mem_q[ra1_i];
    if (ra1_i == 5'd0) begin
      rd1_o = '0;
    end else if (wr_en && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end
  end

  always_comb begin
    rd2_o = mem_q[ra2_i];
    if (ra2_i == 5'd0) begin
      rd2_o = '0;
    end else if (wr_en && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register, register file, control decode and early branch/jump resolve.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0] PcPlus4F,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             RegWriteW,
  input  logic [4:0]       WriteRegW,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             ForwardAD,
  input  logic             ForwardBD,
  input  logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PcPlus4D,
  output logic [1:0]       PcScrD,
  output logic [WIDTH-1:0] PcBranchD,
  output logic [WIDTH-1:0] PcJumpD,
  output logic [WIDTH-1:0] RD1D,
  output logic [WIDTH-1:0] RD2D,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic [4:0]       RdD,
  output logic [WIDTH-1:0] SignImmD,
  output logic             RegWriteD,
  output logic             MemtoRegD,
  output logic             MemWriteD,
  output logic             ALUSrcD,
  output logic             RegDstD,
  output logic             BranchD,
  output logic             JumpD,
  output logic [2:0]       ALUControlD
);

  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  // Stall outranks flush so a stalled branch keeps its slot and re-resolves.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (!StallD) begin
      if (FlushD) begin
        instr_d = '0;
        pc_d    = '0;
      end else begin
        instr_d = InstrF;
        pc_d    = PcPlus4F;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign InstrD   = instr_q;
  assign PcPlus4D = pc_q;

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign RsD    = instr_q[25:21];
  assign RtD    = instr_q[20:16];
  assign RdD    = instr_q[15:11];

  reg_file #(
    .Width (WIDTH),
    .NReg  (NREG)
  ) u_reg_file (
    .clk_i (CLK),
    .rst_i (Reset),
    .we_i  (RegWriteW),
    .wa_i  (WriteRegW),
    .wd_i  (ResultW),
    .ra1_i (RsD),
    .ra2_i (RtD),
    .rd1_o (RD1D),
    .rd2_o (RD2D)
  );

  assign SignImmD  = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};
  assign PcBranchD = pc_q + {SignImmD[WIDTH-3:0], 2'b00};
  assign PcJumpD   = {pc_q[WIDTH-1:WIDTH-4], instr_q[25:0], 2'b00};

  ctrl_t ctrl;

  // R-type with an unrecognised funct (including the all-zero NOP) leaves every control low.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl.alu_ctrl = AluAdd;
          FUNCT_SUB: ctrl.alu_ctrl = AluSub;
          FUNCT_AND: ctrl.alu_ctrl = AluAnd;
          FUNCT_OR:  ctrl.alu_ctrl = AluOr;
          FUNCT_SLT: ctrl.alu_ctrl = AluSlt;
          default:   ctrl.alu_ctrl = AluAnd;
        endcase
        if (funct == FUNCT_ADD || funct == FUNCT_SUB || funct == FUNCT_AND ||
            funct == FUNCT_OR || funct == FUNCT_SLT) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_ctrl   = AluAdd;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = AluAdd;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = AluSub;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = AluAdd;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign RegWriteD   = ctrl.reg_write;
  assign MemtoRegD   = ctrl.mem_to_reg;
  assign MemWriteD   = ctrl.mem_write;
  assign ALUSrcD     = ctrl.alu_src;
  assign RegDstD     = ctrl.reg_dst;
  assign BranchD     = ctrl.branch;
  assign JumpD       = ctrl.jump;
  assign ALUControlD = ctrl.alu_ctrl;

  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             equal_d;
  logic             take_branch;

  assign cmp_a       = ForwardAD ? ALUOutM : RD1D;
  assign cmp_b       = ForwardBD ? ALUOutM : RD2D;
  assign equal_d     = (cmp_a == cmp_b);
  assign take_branch = ctrl.branch && ((opcode == OP_BEQ) ? equal_d : !equal_d);

  always_comb begin
    PcScrD = PCSEL_PLUS4;
    if (ctrl.jump) begin
      PcScrD = PCSEL_JUMP;
    end else if (take_branch) begin
      PcScrD = PCSEL_BRANCH;
    end
  end

endmodule
